// File: rtl/wide_addsub_sequencer.sv
// wide_addsub_sequencer
//   Runs a WORDS*WIDTH-bit add or subtract through one external WIDTH-bit adder
//   (fast_adder). Slices go LSW first and the carry chains from slice to slice.
//
//   Ports
//     clk, rst          : clock (rising edge), asynchronous active-high reset
//     start             : request, sampled only while idle
//     op_in             : 0 = add, 1 = subtract (a - b); latched at start
//     a_in, b_in        : full-width operands; latched at start
//     busy              : high from the accepted start until done
//     done              : one-cycle completion pulse
//     sum_out           : full result, held until the next accepted start
//     carry_out         : final MSW carry (subtract: 1 = no borrow)
//     p, q, cin,
//     operation         : operand slice, carry-in and op select driven to the adder
//     adder_result,
//     adder_carry       : adder outputs, valid ADD_LAT edges after sampling
//
//   Optional build macro SEQ_OVERFLOW_EN adds the `overflow` output, which holds the
//   two's-complement signed overflow of the full-width result.
module wide_addsub_sequencer #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_in,
  input  logic [WIDTH*WORDS-1:0] a_in,
  input  logic [WIDTH*WORDS-1:0] b_in,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum_out,
  output logic                   carry_out,
`ifdef SEQ_OVERFLOW_EN
  output logic                   overflow,
`endif
  output logic [WIDTH-1:0]       p,
  output logic [WIDTH-1:0]       q,
  output logic                   cin,
  output logic                   operation,
  input  logic [WIDTH-1:0]       adder_result,
  input  logic                   adder_carry
);

  localparam int unsigned TotalW = WIDTH * WORDS;
  localparam int unsigned IdxW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CntW   = (ADD_LAT > 1) ? $clog2(ADD_LAT + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e state_q, state_d;

  logic [TotalW-1:0] a_q, b_q;
  logic [TotalW-1:0] part_q;     // slices captured so far
  logic [TotalW-1:0] sum_q;
  logic [TotalW-1:0] sum_merge;  // part_q with the current slice's result inserted
  logic              op_q;
  logic              cin_q;      // chained carry into the current slice
  logic              carry_q;
  logic [IdxW-1:0]   idx_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       base;
  logic              accept;
  logic              wait_last;
  logic              slice_last;

  assign accept     = (state_q == StIdle) && start;
  assign wait_last  = (cnt_q == CntW'(1));
  assign slice_last = (idx_q == LastIdx);
  assign base       = 32'(idx_q) * WIDTH;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (wait_last) state_d = slice_last ? StDone : StIssue;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIssue, StWait: busy = 1'b1;
      StDone:          done = 1'b1;
      default:         ;
    endcase
  end

  always_comb begin
    sum_merge = part_q;
    sum_merge[base +: WIDTH] = adder_result;
  end

`ifdef SEQ_OVERFLOW_EN
  logic ovf_q;
  logic msb_carry_in;
  // Carry into the MSB recovered from the sum bit and the two effective operand bits.
  assign msb_carry_in = adder_result[WIDTH-1] ^ a_q[TotalW-1] ^ (b_q[TotalW-1] ^ op_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == StWait) && wait_last && slice_last) begin
      ovf_q <= msb_carry_in ^ adder_carry;
    end
  end

  assign overflow = ovf_q;
`endif

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      cin_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        op_q  <= op_in;
        cin_q <= op_in;  // subtract = a + ~b + 1
        idx_q <= '0;
      end
      if (state_q == StIssue) begin
        cnt_q <= CntW'(ADD_LAT);
      end
      if (state_q == StWait) begin
        if (!wait_last) begin
          cnt_q <= cnt_q - CntW'(1);
        end else begin
          part_q <= sum_merge;
          cin_q  <= adder_carry;
          if (slice_last) begin
            sum_q   <= sum_merge;
            carry_q <= adder_carry;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
      end
    end
  end

  assign p         = a_q[base +: WIDTH];
  assign q         = b_q[base +: WIDTH];
  assign cin       = cin_q;
  assign operation = op_q;
  assign sum_out   = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_wide_addsub_sequencer.sv
// Bench for wide_addsub_sequencer: behavioural fast_adder model, full-width arithmetic
// reference model, scoreboard queue filled by the driver and drained by a done monitor.
module tb_wide_addsub_sequencer;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned TW      = WIDTH * WORDS;
  localparam int unsigned LATENCY = WORDS * (ADD_LAT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          op_in;
  logic [TW-1:0] a_in, b_in;
  logic          busy, done;
  logic [TW-1:0] sum_out;
  logic          carry_out;
  logic [WIDTH-1:0] p, q, adder_result;
  logic          cin, operation, adder_carry;
`ifdef SEQ_OVERFLOW_EN
  logic          overflow;
`endif

  wide_addsub_sequencer #(
    .WIDTH  (WIDTH),
    .WORDS  (WORDS),
    .ADD_LAT(ADD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_in       (op_in),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .sum_out     (sum_out),
    .carry_out   (carry_out),
`ifdef SEQ_OVERFLOW_EN
    .overflow    (overflow),
`endif
    .p           (p),
    .q           (q),
    .cin         (cin),
    .operation   (operation),
    .adder_result(adder_result),
    .adder_carry (adder_carry)
  );

  always #5 clk = ~clk;

  // fast_adder model: ADD_LAT register stages
  logic [WIDTH:0] pipe [ADD_LAT];
  initial for (int i = 0; i < ADD_LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= {1'b0, p} + {1'b0, (operation ? ~q : q)} + {{WIDTH{1'b0}}, cin};
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {adder_carry, adder_result} = pipe[ADD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [TW-1:0] sum;
    logic          carry;
    logic          ovf;
    logic [31:0]   due;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain full-width arithmetic and sign rules.
  function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic o);
    exp_t e;
    logic [TW:0] full;
    e = '0;
    if (!o) begin
      full    = {1'b0, a} + {1'b0, b};
      e.sum   = full[TW-1:0];
      e.carry = full[TW];
      e.ovf   = (a[TW-1] == b[TW-1]) && (e.sum[TW-1] != a[TW-1]);
    end else begin
      e.sum   = a - b;
      e.carry = (a >= b);
      e.ovf   = (a[TW-1] != b[TW-1]) && (e.sum[TW-1] != a[TW-1]);
    end
    return e;
  endfunction

  function automatic logic [TW-1:0] rand_word();
    logic [TW-1:0] r;
    for (int i = 0; i < TW / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: every done must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", sum_out, e.sum);
        check("carry_out", TW'(carry_out), TW'(e.carry));
        check("latency", TW'(cyc), TW'(e.due));
        check("busy_at_done", TW'(busy), '0);
`ifdef SEQ_OVERFLOW_EN
        check("overflow", TW'(overflow), TW'(e.ovf));
`endif
      end
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sum"}, sum_out, '0);
    check({tag, "_carry"}, TW'(carry_out), '0);
    check({tag, "_busy"}, TW'(busy), '0);
    check({tag, "_done"}, TW'(done), '0);
    check({tag, "_pq"}, TW'({p, q}), '0);
    check({tag, "_cin_op"}, TW'({cin, operation}), '0);
`ifdef SEQ_OVERFLOW_EN
    check({tag, "_ovf"}, TW'(overflow), '0);
`endif
  endtask

  // Issue one operation; optionally pulse start again while busy (must be ignored).
  task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic o,
                       input bit poke);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    op_in = o;
    e     = model(a, b, o);
    e.due = 32'(cyc + 1 + LATENCY);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a_in  = rand_word();
    b_in  = rand_word();
    op_in = ~o;
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  logic [TW-1:0] ones, rep;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_in = 1'b0;
    a_in  = '0;
    b_in  = '0;
    ones  = '1;
    for (int i = 0; i < TW / 16; i++) rep[16*i +: 16] = 16'h1111;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    issue(TW'(64'hFFFF_FFFF_FFFF_FFFF), TW'(1), 1'b0, 1'b0);  // carry ripple
    issue('0, TW'(1), 1'b1, 1'b0);                              // borrow
    issue(rep, rep, 1'b1, 1'b0);                                // equal operands
    issue(ones, TW'(1), 1'b0, 1'b1);                            // wrap, ignored start
    issue({1'b0, ones[TW-2:0]}, TW'(1), 1'b0, 1'b0);            // signed overflow

    // Reset during the WAIT of slice 2
    @(negedge clk);
    start = 1'b1;
    a_in  = rand_word();
    b_in  = rand_word();
    op_in = 1'b0;
    sb.push_back(model(a_in, b_in, op_in));
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", TW'({busy, done}), '0);
    issue(TW'(5), TW'(3), 1'b0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 24; n++) begin
      logic [TW-1:0] ra, rb;
      ra = rand_word();
      rb = ($urandom_range(0, 5) == 0) ? ra : rand_word();
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      issue(ra, rb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", TW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wide_addsub_sequencer.md
Name: wide_addsub_sequencer

Overview:
- Multi-word add/subtract sequencer that sits directly upstream of `fast_adder` and also consumes its outputs.
- Splits a WORDS×WIDTH-bit operation into WIDTH-bit slices, issuing one slice per pass from LSW to MSW.
- Drives the adder's p/q/cin/operation inputs, captures result/carry per slice, and chains carry into the next slice's cin.
- Gives the datapath arbitrary-width add/sub from the single 64-bit adder.

Parameters:
- WIDTH, 64: adder slice width; must match `fast_adder`.
- WORDS, 4: number of slices; operand width is WIDTH*WORDS.
- ADD_LAT, 1: adder latency in clk edges, from operands sampled to result/carry valid.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- op_in  input  1  0 = add, 1 = subtract (a − b); latched at start.
- a_in  input  WIDTH*WORDS  operand A; latched at start.
- b_in  input  WIDTH*WORDS  operand B; latched at start.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle completion pulse.
- sum_out  output  WIDTH*WORDS  full result; held until the next accepted start.
- carry_out  output  1  final carry of the MSW (subtract: 1 = no borrow).
- p  output  WIDTH  to adder, current slice of A.
- q  output  WIDTH  to adder, current slice of B.
- cin  output  1  to adder carry-in.
- operation  output  1  to adder operation select.
- adder_result  input  WIDTH  from adder result.
- adder_carry  input  1  from adder carry.

Behaviour:
- Adder contract:
  - operation=0: computes p + q + cin.
  - operation=1: computes p + ~q + cin.
  - carry is the carry-out of that sum.
- Reset:
  - State is IDLE; slice index is 0.
  - busy, done, carry_out, sum_out, p, q, cin and operation are all 0.
  - Reset mid-operation aborts immediately; partial results are discarded.
- IDLE:
  - start=1 latches a_in, b_in and op_in, sets index=0 and cin=op_in, then goes to ISSUE.
  - busy rises on the same edge.
- ISSUE (1 cycle):
  - p = A[index], q = B[index], operation = latched op, cin = chained carry.
  - Goes to WAIT and loads the wait counter with ADD_LAT.
- WAIT (ADD_LAT cycles):
  - p, q, cin and operation are held stable.
  - On the edge ending the last WAIT cycle: sum[index] ← adder_result and chained carry ← adder_carry.
  - If index = WORDS−1: carry_out ← adder_carry and go to DONE.
  - Otherwise: index+1 and return to ISSUE.
- DONE (1 cycle):
  - done=1 and busy=0; returns to IDLE.
  - sum_out and carry_out stay valid and stable until the next accepted start.
- Latency: done is high WORDS*(ADD_LAT+1) edges after the edge that sampled start. With defaults this is 8.
- sum_out is updated only on the DONE transition; intermediate slices are held internally.
- Timing edge cases:
  - start while busy or in DONE is ignored (no queueing).
  - start in the cycle right after done is accepted normally.
  - Input changes on a_in, b_in and op_in after start do not affect the running operation.
- WORDS=1 is legal: one ISSUE/WAIT pass.
- Wrap: a final carry out of the MSW goes to carry_out only; sum_out wraps modulo 2^(WIDTH*WORDS).

Optional Feature:
- Macro: SEQ_OVERFLOW_EN.
- Defined:
  - Adds output port `overflow` (1 bit, reset 0).
  - Set on the DONE transition to the two's-complement signed overflow of the full-width operation: carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is computed from A's MSB, B's effective MSB (inverted for subtract) and the adder_result MSB of the final slice.
  - Held with sum_out.
- Undefined: no overflow port and no associated logic.

Test Plan:
- Add, carry ripple: a = 0x…0000_FFFFFFFFFFFFFFFF, b = 1, op=0 → sum word0 = 0, word1 = 1, words 2–3 = 0, carry_out=0; done exactly 8 edges after start.
- Subtract, borrow: a = 0, b = 1, op=1 → sum = all ones (256 bits), carry_out=0; with SEQ_OVERFLOW_EN, overflow=0.
- Subtract, equal operands: a = b = 0x1111 replicated, op=1 → sum = 0, carry_out=1.
- Full overflow: a = all ones, b = 1, op=0 → sum = 0, carry_out=1; start pulsed again while busy is ignored, with one done only.
- Reset mid-operation: assert rst during the WAIT of slice 2 → all outputs 0 immediately, state IDLE; a following start with a = 5, b = 3, op=0 gives sum = 8.
- Signed overflow (SEQ_OVERFLOW_EN): a = 0x7FFF…F, b = 1, op=0 → sum = 0x8000…0, overflow=1, carry_out=0.
